seq_moore: RTL and testbench

//   Moore-type serial sequence detector. Samples 1-bit input x each clock and raises

---
 rtl/seq_moore.sv | 76 +++++++
 tb/tb_seq_moore.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_moore.sv
// rtl/seq_moore.sv - Moore serial pattern detector, state = length of matched pattern prefix
module seq_moore #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic count
);

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8
  } state_t;

  localparam logic [3:0] DETECT = 4'(PAT_LEN);

  state_t     state;
  logic [3:0] nxt;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input int i);
    logic [7:0] pv;
    int         j;
    pv = 8'(PATTERN);
    j  = PAT_LEN - 1 - i;
    if (j < 0 || j > 7) return 1'b0;
    return pv[j[2:0]];
  endfunction

  // Longest pattern prefix that is a suffix of (first len pattern bits, b).
  function automatic logic [3:0] next_len(input int len, input logic b);
    int   best;
    int   p;
    logic ok;
    logic sbit;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= len + 1) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_LEN; i++) begin
          if (i < k) begin
            p    = len + 1 - k + i;
            sbit = (p == len) ? b : pat_bit(p);
            if (sbit != pat_bit(i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return 4'(best);
  endfunction

  always_comb begin
    nxt = 4'd0;
    if (int'(state) > PAT_LEN)
      nxt = 4'd0;
    else if (state == DETECT && !OVERLAP)
      nxt = next_len(0, x);
    else
      nxt = next_len(int'(state), x);
  end

  // count is registered from the same next-state value, so it always equals (state == DETECT).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      count <= 1'b0;
    end else begin
      state <= state_t'(nxt);
      count <= (nxt == DETECT);
    end
  end

endmodule

// File: tb/tb_seq_moore.sv
// tb/tb_seq_moore.sv - randomized and directed bench for seq_moore, overlap and non-overlap variants
module tb_seq_moore;

  logic clk;
  logic rst;
  logic x;
  logic count_o;
  logic count_n;

  int nvec;
  int nerr;

  bit hist_o[$];
  bit hist_n[$];

  seq_moore #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) dut_o (
    .clk(clk), .rst(rst), .x(x), .count(count_o)
  );

  seq_moore #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) dut_n (
    .clk(clk), .rst(rst), .x(x), .count(count_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: count=%0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  // The last four bits seen since the history was cleared spell 1101.
  function automatic bit hit(input bit q[$]);
    int         n;
    logic [3:0] w;
    n = q.size();
    if (n < 4) return 1'b0;
    w = {q[n-4], q[n-3], q[n-2], q[n-1]};
    return w == 4'b1101;
  endfunction

  task automatic step(input logic b, input logic r, input string tag);
    bit exp_o;
    bit exp_n;
    @(negedge clk);
    x   = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      hist_o.delete();
      hist_n.delete();
      exp_o = 1'b0;
      exp_n = 1'b0;
    end else begin
      hist_o.push_back(b);
      hist_n.push_back(b);
      exp_o = hit(hist_o);
      exp_n = hit(hist_n);
      if (exp_n) hist_n.delete();
      while (hist_o.size() > 4) void'(hist_o.pop_front());
      while (hist_n.size() > 4) void'(hist_n.pop_front());
    end
    #1;
    check({tag, "/ovl"}, count_o, exp_o);
    check({tag, "/novl"}, count_n, exp_n);
  endtask

  task automatic play(input logic [15:0] bits, input int len, input string tag);
    logic [15:0] v;
    v = bits;
    for (int i = len - 1; i >= 0; i--) step(v[i], 1'b0, tag);
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    x    = 1'b0;
    nvec = 0;
    nerr = 0;

    step(1'b0, 1'b1, "reset");
    step(1'b0, 1'b1, "reset");
    step(1'b0, 1'b0, "idle");

    play(16'b110100, 6, "basic");
    step(1'b0, 1'b1, "reset");
    play(16'b11011010, 8, "overlap");
    step(1'b0, 1'b1, "reset");
    play(16'b111010, 6, "s2loop");
    step(1'b0, 1'b1, "reset");

    play(16'b110, 3, "midrst");
    step(1'b0, 1'b1, "midrst");
    play(16'b1000, 4, "midrst");

    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b0, "rand20");

    // Bias toward 1s so matches are frequent; rare resets land mid-pattern.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
